// File: rtl/xor_chk_pkg.sv
// Shared definitions for the XOR sweep checker.
//   state_t : sweep controller states (IDLE, RUN, DONE)
//   vec_w   : width of the {a,b} vector counter for operand width w
//   cnt_w   : width of the mismatch counter for operand width w; one bit wider
//             than the vector count so a single sweep can never saturate it
package xor_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int vec_w(input int w);
      return 2 * w;
   endfunction

   function automatic int cnt_w(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/xor_ref_model.sv
// Combinational W-bit XOR golden model built only from not/and/or gates as
// (~a & b) | (a & ~b). The checker does not depend on the behavioural ^
// operator, so a broken ^ mapping in the flow cannot hide a broken DUT.
// Ports:
//   a, b : operands
//   y    : a xor b
module xor_ref_model #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      wire na;
      wire nb;
      wire t0;
      wire t1;

      not u_na (na, a[i]);
      not u_nb (nb, b[i]);
      and u_t0 (t0, na, b[i]);
      and u_t1 (t1, a[i], nb);
      or  u_y  (y[i], t0, t1);
   end

endmodule

// File: rtl/xor_sweep_checker.sv
// Exhaustive stimulus engine and checker for a W-bit two-operand XOR datapath.
// Each {a,b} combination is driven for HOLD cycles; LAT cycles after the
// vector is applied the DUT result is compared with the gate-level reference.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : one-cycle pulse, launches a sweep from IDLE or DONE
//   a_out     : operand A to the DUT
//   b_out     : operand B to the DUT
//   dut_y     : DUT result
//   busy      : sweep in progress
//   done      : sweep finished, held until the next start or reset
//   pass      : meaningful while done; high when no mismatch was seen
//   err_count : mismatch count, saturating at all-ones
//   first_err : {a,b} of the first mismatching vector, 0 if none
module xor_sweep_checker
   import xor_chk_pkg::*;
#(
   parameter int W    = 4,
   parameter int HOLD = 3,
   parameter int LAT  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [W-1:0]           a_out,
   output logic [W-1:0]           b_out,
   input  logic [W-1:0]           dut_y,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [cnt_w(W)-1:0]    err_count,
   output logic [vec_w(W)-1:0]    first_err
);

   localparam int VW = vec_w(W);
   localparam int CW = cnt_w(W);

   // HOLD is at most 15, so four bits cover the hold counter
   localparam logic [3:0] HC_LAST = 4'(HOLD - 1);
   localparam logic [3:0] HC_CMP  = 4'(LAT);

   state_t          state;
   state_t          state_nxt;
   logic [VW-1:0]   vec;
   logic [3:0]      hc;
   logic [W-1:0]    exp_y;
   logic            last_cycle;
   logic            launch;
   logic            mismatch;

   xor_ref_model #(.W(W)) u_ref (
      .a (a_out),
      .b (b_out),
      .y (exp_y)
   );

   assign last_cycle = (hc == HC_LAST) && (vec == '1);
   // start is only honoured outside RUN; a pulse during a sweep is dropped
   assign launch     = start && (state != RUN);
   assign mismatch   = (dut_y != exp_y);
   assign pass       = done && (err_count == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_cycle) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The operand registers are loaded on the same edge as vec, so during RUN
   // {a_out,b_out} always equals vec and hc counts cycles since the vector
   // reached the DUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec       <= '0;
         hc        <= '0;
         a_out     <= '0;
         b_out     <= '0;
         err_count <= '0;
         first_err <= '0;
      end else if (launch) begin
         vec       <= '0;
         hc        <= '0;
         a_out     <= '0;
         b_out     <= '0;
         err_count <= '0;
         first_err <= '0;
      end else if (state == RUN) begin
         if ((hc == HC_CMP) && mismatch) begin
            if (err_count != '1) err_count <= err_count + CW'(1);
            // err_count only returns to zero on a new sweep, so zero here
            // identifies the first mismatch of this sweep
            if (err_count == '0) first_err <= {a_out, b_out};
         end
         if (hc == HC_LAST) begin
            hc <= '0;
            // the final vector stays on the outputs through DONE
            if (vec != '1) begin
               vec            <= vec + VW'(1);
               {a_out, b_out} <= vec + VW'(1);
            end
         end else begin
            hc <= hc + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_xor_sweep_checker.sv
// Bench for xor_sweep_checker. Three checker instances share clock and reset:
//   inst 0 : W=4 HOLD=3 LAT=1, registered DUT, optional y[0] stuck-at-0
//   inst 1 : W=4 HOLD=3 LAT=0, DUT with two cycles of latency
//   inst 2 : W=1 HOLD=2 LAT=1, registered DUT, optional y[0] stuck-at-0
// The stimulus pushes the expected end-of-sweep result into a queue when it
// launches a sweep; a monitor pops it when the instance raises done.
module tb_xor_sweep_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int inst;
      int err;
      int pass;
      int first;
      int len;
   } exp_t;

   exp_t sb_q[$];

   // ---------------- instance 0 ----------------
   logic       start_a = 1'b0;
   logic       stuck_a = 1'b0;
   logic [3:0] a_a, b_a, y_a;
   logic       busy_a, done_a, pass_a;
   logic [8:0] err_a;
   logic [7:0] first_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          y_a <= '0;
      else if (stuck_a) y_a <= (a_a ^ b_a) & 4'b1110;
      else              y_a <= a_a ^ b_a;
   end

   xor_sweep_checker #(.W(4), .HOLD(3), .LAT(1)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .a_out(a_a), .b_out(b_a),
      .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_err(first_a)
   );

   // ---------------- instance 1 ----------------
   logic       start_b = 1'b0;
   logic [3:0] a_b, b_b, s1_b, y_b;
   logic       busy_b, done_b, pass_b;
   logic [8:0] err_b;
   logic [7:0] first_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_b <= '0;
         y_b  <= '0;
      end else begin
         s1_b <= a_b ^ b_b;
         y_b  <= s1_b;
      end
   end

   xor_sweep_checker #(.W(4), .HOLD(3), .LAT(0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .a_out(a_b), .b_out(b_b),
      .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_err(first_b)
   );

   // ---------------- instance 2 ----------------
   logic       start_c = 1'b0;
   logic       stuck_c = 1'b0;
   logic       a_c, b_c, y_c;
   logic       busy_c, done_c, pass_c;
   logic [2:0] err_c;
   logic [1:0] first_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          y_c <= 1'b0;
      else if (stuck_c) y_c <= 1'b0;
      else              y_c <= a_c ^ b_c;
   end

   xor_sweep_checker #(.W(1), .HOLD(2), .LAT(1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .a_out(a_c), .b_out(b_c),
      .dut_y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .err_count(err_c), .first_err(first_c)
   );

   // uniform views for the monitor
   logic [2:0]  busy_v, done_v, pass_v;
   logic [31:0] err_v[3];
   logic [31:0] first_v[3];

   always_comb begin
      busy_v     = {busy_c, busy_b, busy_a};
      done_v     = {done_c, done_b, done_a};
      pass_v     = {pass_c, pass_b, pass_a};
      err_v[0]   = 32'(err_a);
      err_v[1]   = 32'(err_b);
      err_v[2]   = 32'(err_c);
      first_v[0] = 32'(first_a);
      first_v[1] = 32'(first_b);
      first_v[2] = 32'(first_c);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      int   busy_cnt[3];
      logic [2:0] done_q;
      exp_t e;
      for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
      done_q = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
            done_q = '0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (busy_v[i]) busy_cnt[i]++;
               if (done_v[i] && !done_q[i]) begin
                  if (sb_q.size() == 0) begin
                     check($sformatf("inst%0d unexpected done", i), 32'(sb_q.size()), 32'd1);
                  end else begin
                     e = sb_q.pop_front();
                     check($sformatf("inst%0d sweep owner", i), 32'(i), 32'(e.inst));
                     check($sformatf("inst%0d err_count", i), err_v[i], 32'(e.err));
                     check($sformatf("inst%0d pass", i), 32'(pass_v[i]), 32'(e.pass));
                     check($sformatf("inst%0d first_err", i), first_v[i], 32'(e.first));
                     check($sformatf("inst%0d busy cycles", i), 32'(busy_cnt[i]), 32'(e.len));
                     check($sformatf("inst%0d busy with done", i), 32'(busy_v[i]), 32'd0);
                  end
                  busy_cnt[i] = 0;
               end
               done_q[i] = done_v[i];
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_start(input int inst, input logic v);
      case (inst)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic pulse_start(input int inst);
      @(negedge clk);
      set_start(inst, 1'b1);
      @(negedge clk);
      set_start(inst, 1'b0);
   endtask

   task automatic wait_done(input int inst, input int budget);
      int n = 0;
      while (!done_v[inst] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("inst%0d done within budget", inst), 32'(done_v[inst]), 32'd1);
   endtask

   task automatic run_sweep(input int inst, input int err, input int pass,
                            input int first, input int len);
      exp_t e;
      e.inst  = inst;
      e.err   = err;
      e.pass  = pass;
      e.first = first;
      e.len   = len;
      sb_q.push_back(e);
      pulse_start(inst);
      wait_done(inst, len + 50);
   endtask

   initial begin : stim
      // reset state
      #1;
      check("rst a_out", 32'(a_a), 32'd0);
      check("rst b_out", 32'(b_a), 32'd0);
      check("rst busy", 32'(busy_a), 32'd0);
      check("rst done", 32'(done_a), 32'd0);
      check("rst pass", 32'(pass_a), 32'd0);
      check("rst err_count", 32'(err_a), 32'd0);
      check("rst first_err", 32'(first_a), 32'd0);
      check("rst busy/done inst1", 32'({busy_b, done_b}), 32'd0);
      check("rst busy/done inst2", 32'({busy_c, done_c}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // reset in the middle of a sweep, at RUN cycle 100
      stuck_a = 1'b1;
      pulse_start(0);
      repeat (99) @(negedge clk);
      check("pre-reset busy", 32'(busy_a), 32'd1);
      check("pre-reset errors seen", 32'(err_a != 0), 32'd1);
      rst = 1'b1;
      #1;
      check("mid-run rst busy", 32'(busy_a), 32'd0);
      check("mid-run rst err_count", 32'(err_a), 32'd0);
      check("mid-run rst a_out", 32'(a_a), 32'd0);
      check("mid-run rst b_out", 32'(b_a), 32'd0);
      check("mid-run rst first_err", 32'(first_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // good DUT: full 256*3-cycle sweep, clean result
      stuck_a = 1'b0;
      run_sweep(0, 0, 1, 0, 768);

      // y[0] stuck-at-0: every vector with a[0]^b[0]=1 fails, first is {0,1}
      stuck_a = 1'b1;
      run_sweep(0, 128, 0, 8'h01, 768);

      // start pulses at RUN cycle 10 and on the final vector cycle are ignored
      stuck_a = 1'b0;
      sb_q.push_back('{inst: 0, err: 0, pass: 1, first: 0, len: 768});
      pulse_start(0);
      repeat (9) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (757) @(negedge clk);
      check("final cycle still busy", 32'(busy_a), 32'd1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("final-cycle start ignored: done", 32'(done_a), 32'd1);
      @(negedge clk);
      check("final-cycle start ignored: busy", 32'(busy_a), 32'd0);
      check("final-cycle start ignored: done held", 32'(done_a), 32'd1);
      check("DONE holds last a_out", 32'(a_a), 32'hF);
      check("DONE holds last b_out", 32'(b_a), 32'hF);

      // DUT latency 2 against LAT=0: each compare sees the previous vector's
      // result; 240 in-row changes plus 14 of 15 row boundaries (a=8 matches)
      run_sweep(1, 254, 0, 8'h01, 768);

      // W=1 HOLD=2: stuck DUT fails vectors 01 and 10, then a rerun from DONE
      // with a good DUT must start with cleared counters
      stuck_c = 1'b1;
      run_sweep(2, 2, 0, 2'b01, 8);
      stuck_c = 1'b0;
      run_sweep(2, 0, 1, 0, 8);

      repeat (3) @(negedge clk);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
